// File: rtl/johnson_counter_param.sv
// johnson_counter_param: WIDTH-bit twisted-ring (Johnson) counter with 2*WIDTH
// states. Adds count enable, up/down direction, a legality-checked parallel
// load, illegal-state detection with optional self-correction, a decoded
// phase index and a one-cycle wrap pulse. Used as a glitch-free multiphase
// sequencer: exactly one bit of q changes per step.
module johnson_counter_param #(
    parameter int  WIDTH        = 4,
    parameter bit  SELF_CORRECT = 1'b1,
    localparam int IDXW         = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,     // asynchronous, active low
    input  logic             en,
    input  logic             dir,       // 0 = up (shift left), 1 = down (shift right)
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [IDXW-1:0]  idx,
    output logic             wrap,
    output logic             err
);

    // Last state of the up sequence (1 followed by zeros); stepping up from it wraps to zero.
    localparam logic [WIDTH-1:0] TOP_STATE = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             q_illegal;
    logic             load_legal;
    logic [IDXW:0]    pop;

    // A Johnson state has at most one boundary between adjacent bits of differing value.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        int edges;
        edges = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (v[i] != v[i+1]) edges++;
        end
        return (edges <= 1);
    endfunction

    assign q_illegal  = !is_legal(q_q);
    assign load_legal = is_legal(load_val);

    // Phase index: number of ones while the MSB is clear, mirrored once the MSB is set.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        pop = '0;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + (IDXW+1)'(q_q[i]);
        end
        if (q_q[WIDTH-1]) idx = IDXW'(2 * WIDTH - int'(pop));
        else              idx = IDXW'(pop);
    end

    // Next-state selection in priority order: correction, load, step, hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = q_illegal;
        if (q_illegal && SELF_CORRECT) begin
            q_d = '0;
        end else if (load) begin
            if (load_legal) q_d   = load_val;
            else            err_d = 1'b1;
        end else if (en) begin
            if (!dir) begin
                q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
                wrap_d = (q_q == TOP_STATE);
            end else begin
                q_d    = {~q_q[0], q_q[WIDTH-1:1]};
                wrap_d = (q_q == '0);
            end
        end
    end

    // State and pulse registers; reset forces the all-zero phase with no pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Self-checking bench for johnson_counter_param. Three instances share the
// control inputs: WIDTH=4 with self-correction, WIDTH=4 flag-only, and WIDTH=7.
// The reference model tracks each counter as a phase number 0..2*WIDTH-1 and
// derives the expected bit pattern from that phase arithmetically.
module tb_johnson_counter_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] load_val4;
    logic [6:0] load_val7;

    logic [3:0] q4, qn;
    logic [2:0] idx4, idxn;
    logic       wrap4, wrapn, err4, errn;
    logic [6:0] q7;
    logic [3:0] idx7;
    logic       wrap7, err7;

    int n_checks;
    int n_fail;

    int  k4, kn, k7;        // model phases
    bit  trk4, trkn;        // model tracking enabled per WIDTH=4 instance

    logic [3:0] up_seq [9];

    johnson_counter_param #(.WIDTH(4), .SELF_CORRECT(1'b1)) dut (
        .clk(clk), .reset(rst_n), .en(en), .dir(dir), .load(load), .load_val(load_val4),
        .q(q4), .idx(idx4), .wrap(wrap4), .err(err4)
    );

    johnson_counter_param #(.WIDTH(4), .SELF_CORRECT(1'b0)) dut_nc (
        .clk(clk), .reset(rst_n), .en(en), .dir(dir), .load(load), .load_val(load_val4),
        .q(qn), .idx(idxn), .wrap(wrapn), .err(errn)
    );

    johnson_counter_param #(.WIDTH(7), .SELF_CORRECT(1'b1)) dut7 (
        .clk(clk), .reset(rst_n), .en(en), .dir(dir), .load(load), .load_val(load_val7),
        .q(q7), .idx(idx7), .wrap(wrap7), .err(err7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit pattern of phase k for a w-bit Johnson counter: k low ones, then ones sliding out the top.
    function automatic logic [31:0] jq(input int w, input int k);
        logic [63:0] ones_w, v;
        ones_w = (64'd1 << w) - 64'd1;
        if (k <= w) v = (64'd1 << k) - 64'd1;
        else        v = (ones_w << (k - w)) & ones_w;
        return v[31:0];
    endfunction

    // Phase number of a pattern, or -1 when it is not a Johnson state.
    function automatic int jidx(input int w, input logic [31:0] v);
        for (int k = 0; k < 2 * w; k++) begin
            if (jq(w, k) == v) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input int w, input int ki, input logic ld, input logic [31:0] lv,
                              input logic e, input logic d,
                              output int ko, output logic wr, output logic er);
        int kl;
        ko = ki;
        wr = 1'b0;
        er = 1'b0;
        if (ld) begin
            kl = jidx(w, lv);
            if (kl >= 0) ko = kl;
            else         er = 1'b1;
        end else if (e) begin
            if (!d) begin
                ko = (ki + 1) % (2 * w);
                wr = (ki == 2 * w - 1);
            end else begin
                ko = (ki + 2 * w - 1) % (2 * w);
                wr = (ki == 0);
            end
        end
    endtask

    // Apply one cycle of inputs, clock once, and compare tracked instances with the model.
    task automatic cycle(input logic ld, input logic [3:0] lv4, input logic [6:0] lv7,
                         input logic e, input logic d);
        int   nk4, nkn, nk7;
        logic w4, e4, wn, en_, w7, e7;
        load = ld; load_val4 = lv4; load_val7 = lv7; en = e; dir = d;
        model_step(4, k4, ld, 32'(lv4), e, d, nk4, w4, e4);
        model_step(4, kn, ld, 32'(lv4), e, d, nkn, wn, en_);
        model_step(7, k7, ld, 32'(lv7), e, d, nk7, w7, e7);
        @(posedge clk);
        #1;
        if (trk4) begin
            check("q4", 32'(q4), jq(4, nk4));
            check("idx4", 32'(idx4), 32'(nk4));
            check("wrap4", 32'(wrap4), 32'(w4));
            check("err4", 32'(err4), 32'(e4));
        end
        if (trkn) begin
            check("qn", 32'(qn), jq(4, nkn));
            check("idxn", 32'(idxn), 32'(nkn));
            check("wrapn", 32'(wrapn), 32'(wn));
            check("errn", 32'(errn), 32'(en_));
        end
        check("q7", 32'(q7), jq(7, nk7));
        check("idx7", 32'(idx7), 32'(nk7));
        check("wrap7", 32'(wrap7), 32'(w7));
        check("err7", 32'(err7), 32'(e7));
        k4 = nk4; kn = nkn; k7 = nk7;
    endtask

    initial begin
        int   wraps;
        logic [3:0] lv4;
        logic [6:0] lv7;
        n_checks = 0;
        n_fail   = 0;
        k4 = 0; kn = 0; k7 = 0;
        trk4 = 1'b1; trkn = 1'b1;
        up_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};

        rst_n = 1'b0; en = 1'b1; dir = 1'b0; load = 1'b0; load_val4 = '0; load_val7 = '0;

        // Reset state, including one clock edge while reset is held.
        #3;
        check("rst_q4", 32'(q4), 32'd0);
        check("rst_idx4", 32'(idx4), 32'd0);
        check("rst_wrap4", 32'(wrap4), 32'd0);
        check("rst_err4", 32'(err4), 32'd0);
        @(posedge clk); #1;
        check("rst_hold_q4", 32'(q4), 32'd0);
        check("rst_hold_q7", 32'(q7), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Up count through a full WIDTH=4 cycle plus one.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 4'd0, 7'd0, 1'b1, 1'b0);
            check("up_seq", 32'(q4), 32'(up_seq[i]));
        end

        // From zero, count down: 1000 (wrap), 1100, 1110.
        cycle(1'b1, 4'b0000, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 7'd0, 1'b1, 1'b1);
        check("down_end", 32'(q4), 32'(4'b1110));

        // Loads take priority over en; an illegal load holds q and flags err once.
        cycle(1'b1, 4'b0011, 7'd0, 1'b1, 1'b0);
        cycle(1'b1, 4'b1110, 7'd0, 1'b1, 1'b0);
        check("load_ok_q", 32'(q4), 32'(4'b1110));
        cycle(1'b1, 4'b0101, 7'b0101010, 1'b1, 1'b0);
        check("load_bad_q", 32'(q4), 32'(4'b1110));
        check("load_bad_err", 32'(err4), 32'd1);
        cycle(1'b0, 4'd0, 7'd0, 1'b0, 1'b0);

        // Self-correcting instance: illegal state returns to zero, ignoring load and en.
        trk4 = 1'b0;
        force dut.q_q = 4'b0110;
        #1;
        release dut.q_q;
        check("forced_q4", 32'(q4), 32'(4'b0110));
        cycle(1'b1, 4'b0001, 7'd0, 1'b1, 1'b0);
        check("corr_q4", 32'(q4), 32'd0);
        check("corr_idx4", 32'(idx4), 32'd0);
        check("corr_err4", 32'(err4), 32'd1);
        check("corr_wrap4", 32'(wrap4), 32'd0);
        k4 = 0;
        trk4 = 1'b1;
        cycle(1'b0, 4'd0, 7'd0, 1'b0, 1'b0);

        // Flag-only instance: err stays high while illegal, stepping stays illegal, legal load recovers.
        trkn = 1'b0;
        force dut_nc.q_q = 4'b0110;
        #1;
        release dut_nc.q_q;
        cycle(1'b0, 4'd0, 7'd0, 1'b0, 1'b0);
        check("nc_hold_q", 32'(qn), 32'(4'b0110));
        check("nc_hold_err", 32'(errn), 32'd1);
        cycle(1'b0, 4'd0, 7'd0, 1'b1, 1'b0);
        check("nc_step_q", 32'(qn), 32'(4'b1101));
        check("nc_step_illegal", 32'(jidx(4, 32'(qn)) < 0), 32'd1);
        check("nc_step_err", 32'(errn), 32'd1);
        cycle(1'b1, 4'b0011, 7'd0, 1'b0, 1'b0);
        check("nc_recover_q", 32'(qn), 32'(4'b0011));
        check("nc_recover_err", 32'(errn), 32'd1);
        kn = 2;
        trkn = 1'b1;
        cycle(1'b0, 4'd0, 7'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of the high clock phase.
        cycle(1'b1, 4'b0111, 7'b0000111, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_q4", 32'(q4), 32'd0);
        check("async_idx4", 32'(idx4), 32'd0);
        check("async_q7", 32'(q7), 32'd0);
        check("async_wrap4", 32'(wrap4), 32'd0);
        check("async_err4", 32'(err4), 32'd0);
        k4 = 0; kn = 0; k7 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 4'd0, 7'd0, 1'b1, 1'b0);
        check("resume_q4", 32'(q4), 32'(4'b0001));

        // WIDTH=7 full up cycle from zero: back to zero with exactly one wrap.
        cycle(1'b1, 4'd0, 7'd0, 1'b0, 1'b0);
        wraps = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 4'd0, 7'd0, 1'b1, 1'b0);
            if (wrap7) wraps++;
        end
        check("w7_final_q", 32'(q7), 32'd0);
        check("w7_wraps", 32'(wraps), 32'd1);

        // Randomized traffic: direction changes, random legal and illegal loads.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) lv4 = 4'(jq(4, int'($urandom_range(0, 7))));
            else                           lv4 = 4'($urandom);
            if ($urandom_range(0, 1) == 0) lv7 = 7'(jq(7, int'($urandom_range(0, 13))));
            else                           lv7 = 7'($urandom);
            cycle(($urandom_range(0, 7) == 0), lv4, lv7,
                  ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
